// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register window scheduler and the window mux checkers:
// FSM states, the permutation codes, and the (row phase, column phase) -> code map.
package sr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_REFILL,
    S_FIN
  } state_t;

  localparam logic [2:0] MUX_R0C0 = 3'b000;
  localparam logic [2:0] MUX_R0C1 = 3'b001;
  localparam logic [2:0] MUX_R1C0 = 3'b011;
  localparam logic [2:0] MUX_R1C1 = 3'b010;
  localparam logic [2:0] MUX_R2C0 = 3'b100;
  localparam logic [2:0] MUX_R2C1 = 3'b101;

  // Row phase 3 cannot occur; it falls back to the identity code.
  function automatic logic [2:0] mux_code(input logic [1:0] r, input logic c);
    logic [2:0] code;
    case (r)
      2'd0:    code = c ? MUX_R0C1 : MUX_R0C0;
      2'd1:    code = c ? MUX_R1C1 : MUX_R1C0;
      2'd2:    code = c ? MUX_R2C1 : MUX_R2C0;
      default: code = MUX_R0C0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sr_win_sched.sv
// Window scheduler: primes the 3-row register array, walks the COL_NUM x ROW_NUM grid,
// refills the oldest row at each row change and steers the window mux by circular phase.
module sr_win_sched
  import sr_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [CW-1:0] COL_NUM,
  input  logic [CW-1:0] ROW_NUM,
  output logic          REG_WR_EN,
  output logic [1:0]    REG_WR_ROW,
  output logic [2:0]    CTRL_MUX_6_1,
  output logic          OPU_VALID,
  input  logic          OPU_READY,
  output logic          BUSY,
  output logic          DONE
);

  state_t        state, state_nxt;
  logic [CW-1:0] col_lim, col_lim_nxt;
  logic [CW-1:0] row_lim, row_lim_nxt;
  logic [CW-1:0] x, x_nxt;
  logic [CW-1:0] y, y_nxt;
  logic [1:0]    rph, rph_nxt;
  logic          cph, cph_nxt;
  logic [1:0]    pcnt, pcnt_nxt;
  logic          hs;

  logic          wr_en_nxt;
  logic [1:0]    wr_row_nxt;
  logic [2:0]    mux_nxt;
  logic          valid_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  assign hs = OPU_VALID & OPU_READY;

  always_comb begin
    state_nxt   = state;
    col_lim_nxt = col_lim;
    row_lim_nxt = row_lim;
    x_nxt       = x;
    y_nxt       = y;
    rph_nxt     = rph;
    cph_nxt     = cph;
    pcnt_nxt    = pcnt;

    case (state)
      S_IDLE: begin
        if (START) begin
          if (COL_NUM != '0 && ROW_NUM != '0) begin
            // Limits are stored as size-1 so a full-scale size never overflows.
            col_lim_nxt = COL_NUM - CW'(1);
            row_lim_nxt = ROW_NUM - CW'(1);
            x_nxt       = '0;
            y_nxt       = '0;
            rph_nxt     = 2'd0;
            cph_nxt     = 1'b0;
            pcnt_nxt    = 2'd0;
            state_nxt   = S_PRIME;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_PRIME: begin
        if (pcnt == 2'd2) state_nxt = S_RUN;
        else              pcnt_nxt  = pcnt + 2'd1;
      end
      S_RUN: begin
        if (hs) begin
          if (x != col_lim) begin
            x_nxt   = x + CW'(1);
            cph_nxt = ~cph;
          end else if (y != row_lim) begin
            x_nxt     = '0;
            cph_nxt   = 1'b0;
            y_nxt     = y + CW'(1);
            state_nxt = S_REFILL;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_REFILL: begin
        rph_nxt   = (rph == 2'd2) ? 2'd0 : rph + 2'd1;
        state_nxt = S_RUN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are derived from the upcoming state so they can be registered.
    wr_en_nxt  = (state_nxt == S_PRIME) || (state_nxt == S_REFILL);
    wr_row_nxt = 2'd0;
    if (state_nxt == S_PRIME)  wr_row_nxt = pcnt_nxt;
    if (state_nxt == S_REFILL) wr_row_nxt = rph_nxt;
    valid_nxt  = (state_nxt == S_RUN);
    mux_nxt    = valid_nxt ? mux_code(rph_nxt, cph_nxt) : 3'b000;
    busy_nxt   = (state_nxt == S_PRIME) || (state_nxt == S_RUN) || (state_nxt == S_REFILL);
    done_nxt   = (state_nxt == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      REG_WR_EN    <= 1'b0;
      REG_WR_ROW   <= 2'd0;
      CTRL_MUX_6_1 <= 3'b000;
      OPU_VALID    <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      state        <= state_nxt;
      REG_WR_EN    <= wr_en_nxt;
      REG_WR_ROW   <= wr_row_nxt;
      CTRL_MUX_6_1 <= mux_nxt;
      OPU_VALID    <= valid_nxt;
      BUSY         <= busy_nxt;
      DONE         <= done_nxt;
    end
  end

  // Position counters are reinitialised at every accepted START.
  always_ff @(posedge CLK) begin
    col_lim <= col_lim_nxt;
    row_lim <= row_lim_nxt;
    x       <= x_nxt;
    y       <= y_nxt;
    rph     <= rph_nxt;
    cph     <= cph_nxt;
    pcnt    <= pcnt_nxt;
  end

endmodule
